// File: rtl/data_ram_dump_reader.sv
// data_ram_dump_reader: sweeps a contiguous RAM address range and streams the
// words out over a valid/ready interface. m_last marks the final word and done
// pulses once the dump has been fully accepted.
module data_ram_dump_reader #(
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wrEn,
  input  logic [WIDTH-1:0]      ram_dataOut,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic [ADDR_WIDTH:0]   accepted_q;
  logic                  infl_q;       // a read was issued last cycle; its data is on ram_dataOut now
  logic                  infl_last_q;  // that read is the final word of the dump
  logic [WIDTH-1:0]      tail_data;
  logic                  tail_last;
  logic                  tail_valid;

  logic                  pop;
  logic                  issue;
  logic                  issue_last;
  logic                  final_pop;
  logic [1:0]            occ;
  logic [ADDR_WIDTH-1:0] addr_next;

  // The reader never writes the RAM.
  assign ram_wrEn = 1'b0;

  // Issue decision: the FIFO head register is entry 0, the tail register entry 1.
  // A read issued now lands at the end of next cycle, so it is allowed only if
  // the occupancy left after this cycle's push/pop still has a free slot.
  always_comb begin
    pop        = m_valid & m_ready;
    occ        = 2'(m_valid) + 2'(tail_valid) + 2'(infl_q);
    issue      = 1'b0;
    if (state == S_RUN && issued_q != len_q) begin
      issue = (occ < 2'd2) || (occ == 2'd2 && pop);
    end
    issue_last = issue && ((issued_q + CNT_ONE) == len_q);
    final_pop  = pop && ((accepted_q + CNT_ONE) == len_q);
    addr_next  = (ram_addr == ADDR_MAX) ? '0 : ram_addr + ADDR_ONE;
  end

  // Control FSM, address/counter registers and the 2-entry output FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      tail_data   <= '0;
      tail_last   <= 1'b0;
      tail_valid  <= 1'b0;
      ram_addr    <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      infl_q      <= issue;
      infl_last_q <= issue_last;
      if (pop) begin
        accepted_q <= accepted_q + CNT_ONE;
      end

      // FIFO: push comes from the returning read, pop from the handshake.
      case ({infl_q, pop})
        2'b11: begin
          if (tail_valid) begin
            m_data    <= tail_data;
            m_last    <= tail_last;
            tail_data <= ram_dataOut;
            tail_last <= infl_last_q;
          end else begin
            m_data <= ram_dataOut;
            m_last <= infl_last_q;
          end
        end
        2'b01: begin
          if (tail_valid) begin
            m_data     <= tail_data;
            m_last     <= tail_last;
            tail_valid <= 1'b0;
          end else begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
          end
        end
        2'b10: begin
          if (!m_valid) begin
            m_data  <= ram_dataOut;
            m_last  <= infl_last_q;
            m_valid <= 1'b1;
          end else begin
            tail_data  <= ram_dataOut;
            tail_last  <= infl_last_q;
            tail_valid <= 1'b1;
          end
        end
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (start) begin
            len_q      <= length;
            issued_q   <= '0;
            accepted_q <= '0;
            if (length != '0) begin
              state    <= S_RUN;
              busy     <= 1'b1;
              ram_addr <= start_addr;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            issued_q <= issued_q + CNT_ONE;
            ram_addr <= addr_next;
            if (issue_last) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (final_pop) begin
            state    <= S_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            ram_addr <= '0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_dump_reader.sv
// Testbench for data_ram_dump_reader: a behavioural RAM preloaded with
// mem[i] = i+1, a table of dump vectors, and hand-written timing/corner sequences.
module tb_data_ram_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] start_addr = '0;
  logic [12:0] length = '0;
  logic [11:0] ram_addr;
  logic        ram_wrEn;
  logic [11:0] ram_dataOut = '0;
  logic [11:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        busy;
  logic        done;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic        wr_seen = 1'b0;

  logic [11:0] mem [4096];

  data_ram_dump_reader #(.WIDTH(12), .DEPTH(4096), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .ram_addr(ram_addr), .ram_wrEn(ram_wrEn), .ram_dataOut(ram_dataOut),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data valid the cycle after the address.
  always @(posedge clk) begin
    ram_dataOut <= mem[ram_addr];
    if (ram_wrEn) wr_seen <= 1'b1;
  end

  typedef struct {
    logic [11:0] sa;
    logic [12:0] len;
    logic [15:0] pat;        // m_ready per cycle, bit 0 = cycle T+1
    int unsigned poke;       // cycle offset of a spurious start (0 = none)
    logic [11:0] exp_first;
    logic [11:0] exp_last;
    int unsigned exp_count;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Wait (bounded) for the done pulse, then one more cycle back into IDLE.
  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    tick();
  endtask

  task automatic run_dump(input int idx, input vec_t v);
    int unsigned cyc = 0, got = 0, extra = 0, stab_err = 0, maxd = 0, hs_cyc = 32'hFFFF_FFFF;
    int unsigned budget;
    logic        fin = 1'b0, prev_stall = 1'b0, prev_l = 1'b0;
    logic [11:0] prev_d = '0, first_w = '0, last_w = '0, expw, d;
    string       tag;
    tag    = $sformatf("v%0d", idx);
    budget = 32'(v.len) * 4 + 40;
    start      = 1'b1;
    start_addr = v.sa;
    length     = v.len;
    tick();
    while (!fin && cyc < budget) begin
      start = (v.poke != 0 && cyc == v.poke);
      if (start) begin
        start_addr = 12'd0;
        length     = 13'd2;
      end
      m_ready = v.pat[cyc % 16];
      if (done) begin
        fin = 1'b1;
        chk({tag, "_done_timing"}, cyc, hs_cyc + 1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_valid_at_done"}, 32'(m_valid), 32'd0);
        chk({tag, "_addr_at_done"}, 32'(ram_addr), 32'd0);
      end else begin
        if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) stab_err++;
        if (busy) begin
          d = ram_addr - (v.sa + 12'(got));
          if (32'(d) > maxd) maxd = 32'(d);
        end
        if (m_valid && m_ready) begin
          if (got >= 32'(v.len)) begin
            extra++;
          end else begin
            expw = v.sa + 12'(got) + 12'd1;
            chk($sformatf("%s_word%0d", tag, got), 32'(m_data), 32'(expw));
            chk($sformatf("%s_last%0d", tag, got), 32'(m_last), 32'(got == 32'(v.len) - 1));
            if (got == 0) first_w = m_data;
            last_w = m_data;
            got++;
            if (got == 32'(v.len)) hs_cyc = cyc;
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_d     = m_data;
        prev_l     = m_last;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_finished"}, 32'(fin), 32'd1);
    chk({tag, "_count"}, got, v.exp_count);
    chk({tag, "_first"}, 32'(first_w), 32'(v.exp_first));
    chk({tag, "_lastword"}, 32'(last_w), 32'(v.exp_last));
    chk({tag, "_extra"}, extra, 32'd0);
    chk({tag, "_stall_stable"}, stab_err, 32'd0);
    chk({tag, "_ahead_le2"}, 32'(maxd <= 2), 32'd1);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned cnt_done, cnt_valid;
    for (int i = 0; i < 4096; i++) mem[i] = 12'(i + 1);

    //          sa        len       pat        poke first     last      count
    vecs[0] = '{12'd0,    13'd4,    16'hFFFF, 0, 12'd1,    12'd4,    4};
    vecs[1] = '{12'd10,   13'd6,    16'hFFA7, 0, 12'd11,   12'd16,   6};
    vecs[2] = '{12'd4094, 13'd4,    16'hFFFF, 0, 12'd4095, 12'd2,    4};
    vecs[3] = '{12'd100,  13'd9,    16'h5555, 0, 12'd101,  12'd109,  9};
    vecs[4] = '{12'd4093, 13'd5,    16'h3333, 0, 12'd4094, 12'd2,    5};
    vecs[5] = '{12'd0,    13'd1,    16'hFFFF, 0, 12'd1,    12'd1,    1};
    vecs[6] = '{12'd200,  13'd3,    16'h0F0F, 0, 12'd201,  12'd203,  3};
    vecs[7] = '{12'd50,   13'd5,    16'hFFFF, 2, 12'd51,   12'd55,   5};
    vecs[8] = '{12'd0,    13'd4096, 16'hFFFF, 0, 12'd1,    12'd0,    4096};

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    tick();

    // Exact latency: start in T, words in T+3..T+6, last in T+6, done in T+7
    begin
      logic [6:0] e_valid = 7'b0111100; // bit k-1 = cycle T+k
      logic [6:0] e_busy  = 7'b0111111;
      logic [6:0] e_last  = 7'b0100000;
      logic [6:0] e_done  = 7'b1000000;
      start = 1'b1; start_addr = 12'd0; length = 13'd4; m_ready = 1'b1;
      for (int k = 1; k <= 7; k++) begin
        tick();
        start = 1'b0;
        chk($sformatf("lat_valid_T%0d", k), 32'(m_valid), 32'(e_valid[k-1]));
        chk($sformatf("lat_busy_T%0d", k), 32'(busy), 32'(e_busy[k-1]));
        chk($sformatf("lat_last_T%0d", k), 32'(m_last), 32'(e_last[k-1]));
        chk($sformatf("lat_done_T%0d", k), 32'(done), 32'(e_done[k-1]));
        if (k >= 3 && k <= 6) chk($sformatf("lat_data_T%0d", k), 32'(m_data), k - 2);
      end
      tick();
    end

    // Wrap: ram_addr sequence 4094,4095,0,1
    begin
      logic [11:0] e_addr [4] = '{12'd4094, 12'd4095, 12'd0, 12'd1};
      start = 1'b1; start_addr = 12'd4094; length = 13'd4; m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        start = 1'b0;
        chk($sformatf("wrap_addr%0d", k), 32'(ram_addr), 32'(e_addr[k]));
      end
      wait_done("wrap", 20);
    end

    // length = 0: done in T+1, never busy or valid
    start = 1'b1; start_addr = 12'd7; length = 13'd0;
    tick();
    start = 1'b0;
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_valid", 32'(m_valid), 32'd0);
    tick();
    chk("len0_done_pulse", 32'(done), 32'd0);
    chk("len0_valid2", 32'(m_valid), 32'd0);

    // Reset mid-dump: outputs cleared next cycle, no done afterwards
    start = 1'b1; start_addr = 12'd300; length = 13'd20; m_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("mid_valid_before_rst", 32'(m_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_addr", 32'(ram_addr), 32'd0);
    chk("mid_rst_data", 32'(m_data), 32'd0);
    chk("mid_rst_last", 32'(m_last), 32'd0);
    m_ready = 1'b1;
    cnt_done = 0;
    cnt_valid = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) cnt_done++;
      if (m_valid) cnt_valid++;
    end
    chk("mid_rst_no_done", cnt_done, 32'd0);
    chk("mid_rst_no_valid", cnt_valid, 32'd0);

    // Table-driven dumps (includes stalls, wrap, spurious start, full depth)
    for (int i = 0; i < 9; i++) begin
      run_dump(i, vecs[i]);
      tick();
    end

    chk("wrEn_never", 32'(wr_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
